// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/bubble/flush sequencer for the Fetch-Decode-Exec-Mem pipeline.
// Handles RAW hazards (no forwarding), taken-jump flushes, data-memory wait and debug halts.
module pipeline_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 2,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             dec_rs1_idx,
   input  logic [4:0]             dec_rs2_idx,
   input  logic                   dec_rs1_used,
   input  logic                   dec_rs2_used,
   input  logic [4:0]             ex_rd_idx,
   input  logic                   ex_reg_write_enable,
   input  logic [4:0]             mem_rd_idx,
   input  logic                   mem_reg_write_enable,
   input  logic                   jump_enable,
   input  logic                   mem_busy,
   input  logic [1:0]             debug,
   output logic                   stall_fetch,
   output logic                   stall_decode,
   output logic                   stall_exec,
   output logic                   stall_mem,
   output logic                   bubble_exec,
   output logic                   flush_decode,
   output logic                   halted,
   output logic [1:0]             halt_cause,
   output logic [COUNT_WIDTH-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_DRAIN    = 2'b10,
      ST_HALTED   = 2'b11
   } state_t;

   localparam logic [3:0]             DRAIN_LOAD = 4'(DRAIN_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [3:0]             drain_q, drain_d;
   logic [1:0]             cause_q, cause_d;
   logic                   flush_pend_q, flush_pend_d;
   logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic                   hazard_s;
   logic                   halt_req_s;

   // x0 is hard-wired to zero, so a write to it never creates a dependency.
   function automatic logic src_hazard(
      input logic       used,
      input logic [4:0] idx,
      input logic [4:0] ex_rd,
      input logic       ex_we,
      input logic [4:0] mem_rd,
      input logic       mem_we
   );
      return used && (idx != 5'd0) &&
             ((ex_we && (idx == ex_rd)) || (mem_we && (idx == mem_rd)));
   endfunction

   assign hazard_s = src_hazard(dec_rs1_used, dec_rs1_idx, ex_rd_idx, ex_reg_write_enable,
                                mem_rd_idx, mem_reg_write_enable) ||
                     src_hazard(dec_rs2_used, dec_rs2_idx, ex_rd_idx, ex_reg_write_enable,
                                mem_rd_idx, mem_reg_write_enable);
   assign halt_req_s = (debug == 2'b01) || (debug == 2'b10);

   // Sequencer next-state and per-stage stall/bubble decode
   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      cause_d      = cause_q;
      stall_fetch  = 1'b0;
      stall_decode = 1'b0;
      stall_exec   = 1'b0;
      stall_mem    = 1'b0;
      bubble_exec  = 1'b0;
      halted       = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (halt_req_s) begin
               stall_fetch  = 1'b1;
               stall_decode = 1'b1;
               bubble_exec  = 1'b1;
               cause_d      = debug;
               drain_d      = DRAIN_LOAD;
               state_d      = ST_DRAIN;
            end else if (mem_busy) begin
               stall_fetch  = 1'b1;
               stall_decode = 1'b1;
               stall_exec   = 1'b1;
               stall_mem    = 1'b1;
               state_d      = ST_MEM_WAIT;
            end else if (hazard_s) begin
               stall_fetch  = 1'b1;
               stall_decode = 1'b1;
               bubble_exec  = 1'b1;
               state_d      = ST_RUN;
            end else begin
               state_d      = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            stall_exec   = 1'b1;
            stall_mem    = 1'b1;
            if (!mem_busy) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_MEM_WAIT;
            end
         end
         ST_DRAIN: begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            // A busy memory freezes the drain: Exec/Mem hold instead of receiving a bubble.
            if (mem_busy) begin
               stall_exec  = 1'b1;
               stall_mem   = 1'b1;
               bubble_exec = 1'b0;
            end else begin
               bubble_exec = 1'b1;
               drain_d     = drain_q - 4'd1;
               if (drain_q <= 4'd1) begin
                  state_d = ST_HALTED;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_HALTED: begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            stall_exec   = 1'b1;
            stall_mem    = 1'b1;
            halted       = 1'b1;
         end
         default: begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            stall_exec   = 1'b1;
            stall_mem    = 1'b1;
            state_d      = ST_RUN;
         end
      endcase
   end

   // Pending jump flush and saturating stall-cycle counter
   always_comb begin
      flush_pend_d = flush_pend_q;
      stall_cnt_d  = stall_cnt_q;
      if (flush_pend_q && !stall_decode) begin
         flush_pend_d = 1'b0;
      end else if ((state_q == ST_RUN) && jump_enable && !stall_decode) begin
         flush_pend_d = 1'b1;
      end else begin
         flush_pend_d = flush_pend_q;
      end
      if (stall_decode && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State and registered-output flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         drain_q      <= 4'd0;
         cause_q      <= 2'b00;
         flush_pend_q <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         drain_q      <= drain_d;
         cause_q      <= cause_d;
         flush_pend_q <= flush_pend_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign flush_decode = flush_pend_q;
   assign halt_cause   = cause_q;
   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl with a small scoreboard queue and
// hand-written sequences for halt timing, reset recovery and counter saturation.
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  rs1, rs2, exrd, memrd;
   logic        u1, u2, exwe, memwe, jmp, busy;
   logic [1:0]  dbg;

   logic        sf, sd, se, sm, bub, fl, hlt;
   logic [1:0]  cause;
   logic [15:0] cnt;

   logic        sf2, sd2, se2, sm2, bub2, fl2, hlt2;
   logic [1:0]  cause2;
   logic [2:0]  cnt2;

   int n_vec  = 0;
   int n_miss = 0;

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(2), .COUNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .dec_rs1_idx(rs1), .dec_rs2_idx(rs2), .dec_rs1_used(u1), .dec_rs2_used(u2),
      .ex_rd_idx(exrd), .ex_reg_write_enable(exwe),
      .mem_rd_idx(memrd), .mem_reg_write_enable(memwe),
      .jump_enable(jmp), .mem_busy(busy), .debug(dbg),
      .stall_fetch(sf), .stall_decode(sd), .stall_exec(se), .stall_mem(sm),
      .bubble_exec(bub), .flush_decode(fl), .halted(hlt),
      .halt_cause(cause), .stall_cycles(cnt)
   );

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(1), .COUNT_WIDTH(3)) dut2 (
      .clk(clk), .reset(reset),
      .dec_rs1_idx(rs1), .dec_rs2_idx(rs2), .dec_rs1_used(u1), .dec_rs2_used(u2),
      .ex_rd_idx(exrd), .ex_reg_write_enable(exwe),
      .mem_rd_idx(memrd), .mem_reg_write_enable(memwe),
      .jump_enable(jmp), .mem_busy(busy), .debug(dbg),
      .stall_fetch(sf2), .stall_decode(sd2), .stall_exec(se2), .stall_mem(sm2),
      .bubble_exec(bub2), .flush_decode(fl2), .halted(hlt2),
      .halt_cause(cause2), .stall_cycles(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic [4:0]  exrd;
      logic        exwe;
      logic [4:0]  memrd;
      logic        memwe;
      logic        jmp;
      logic        busy;
      logic [1:0]  dbg;
      logic [3:0]  stl;      // {fetch, decode, exec, mem} during the cycle
      logic        bub;
      logic        hlt;
      logic        fl_after;
      logic [1:0]  cause_after;
      logic [15:0] cnt_after;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   function automatic vec_t mk(
      input string n,
      input logic [4:0] a_rs1, input logic a_u1, input logic [4:0] a_rs2, input logic a_u2,
      input logic [4:0] a_exrd, input logic a_exwe, input logic [4:0] a_memrd, input logic a_memwe,
      input logic a_jmp, input logic a_busy, input logic [1:0] a_dbg,
      input logic [3:0] e_stl, input logic e_bub, input logic e_hlt,
      input logic e_fl, input logic [1:0] e_cause, input logic [15:0] e_cnt);
      vec_t v;
      v.name = n;
      v.rs1 = a_rs1; v.u1 = a_u1; v.rs2 = a_rs2; v.u2 = a_u2;
      v.exrd = a_exrd; v.exwe = a_exwe; v.memrd = a_memrd; v.memwe = a_memwe;
      v.jmp = a_jmp; v.busy = a_busy; v.dbg = a_dbg;
      v.stl = e_stl; v.bub = e_bub; v.hlt = e_hlt;
      v.fl_after = e_fl; v.cause_after = e_cause; v.cnt_after = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
      exrd = 5'd0; exwe = 1'b0; memrd = 5'd0; memwe = 1'b0;
      jmp = 1'b0; busy = 1'b0; dbg = 2'b00;
   endtask

   // Called at posedge+1; asserts reset mid-cycle and checks values before any edge.
   task automatic do_reset(input string tag);
      idle_inputs();
      #3;
      reset = 1'b1;
      #1;
      chk({tag, "_stalls"}, {28'd0, sf, sd, se, sm}, 32'd0);
      chk({tag, "_bubble"}, {31'd0, bub}, 32'd0);
      chk({tag, "_halted"}, {31'd0, hlt}, 32'd0);
      chk({tag, "_flush"}, {31'd0, fl}, 32'd0);
      chk({tag, "_cause"}, {30'd0, cause}, 32'd0);
      chk({tag, "_cnt"}, {16'd0, cnt}, 32'd0);
      chk({tag, "_halted2"}, {31'd0, hlt2}, 32'd0);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      reset = 1'b1;
      idle_inputs();
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      do_reset("por");

      //                 name         rs1  u1 rs2  u2 exrd we memrd we jmp busy dbg    stalls   bub hlt fl cause  cnt
      vecs.push_back(mk("idle",       5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,2'b00,16'd0));
      vecs.push_back(mk("raw_ex",     5'd5,1'b1,5'd0,1'b0,5'd5,1'b1,5'd0,1'b0,1'b0,1'b0,2'b00,4'b1100,1'b1,1'b0,1'b0,2'b00,16'd1));
      vecs.push_back(mk("x0_write",   5'd0,1'b0,5'd0,1'b1,5'd0,1'b1,5'd0,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,2'b00,16'd1));
      vecs.push_back(mk("raw_mem",    5'd0,1'b0,5'd7,1'b1,5'd0,1'b0,5'd7,1'b1,1'b0,1'b0,2'b00,4'b1100,1'b1,1'b0,1'b0,2'b00,16'd2));
      vecs.push_back(mk("rs_unused",  5'd9,1'b0,5'd0,1'b0,5'd9,1'b1,5'd0,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,2'b00,16'd2));
      vecs.push_back(mk("no_write",   5'd9,1'b1,5'd0,1'b0,5'd9,1'b0,5'd9,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,2'b00,16'd2));
      vecs.push_back(mk("jump",       5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b1,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b1,2'b00,16'd2));
      vecs.push_back(mk("jump_clear", 5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,2'b00,16'd2));
      vecs.push_back(mk("jump_haz",   5'd5,1'b1,5'd0,1'b0,5'd5,1'b1,5'd0,1'b0,1'b1,1'b0,2'b00,4'b1100,1'b1,1'b0,1'b0,2'b00,16'd3));
      vecs.push_back(mk("busy1",      5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,2'b00,4'b1111,1'b0,1'b0,1'b0,2'b00,16'd4));
      vecs.push_back(mk("busy2",      5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,2'b00,4'b1111,1'b0,1'b0,1'b0,2'b00,16'd5));
      vecs.push_back(mk("busy3",      5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,2'b00,4'b1111,1'b0,1'b0,1'b0,2'b00,16'd6));
      vecs.push_back(mk("wait_end",   5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b00,4'b1111,1'b0,1'b0,1'b0,2'b00,16'd7));
      vecs.push_back(mk("run_again",  5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,2'b00,16'd7));
      vecs.push_back(mk("jmp2",       5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b1,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b1,2'b00,16'd7));
      vecs.push_back(mk("jbusy1",     5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,2'b00,4'b1111,1'b0,1'b0,1'b1,2'b00,16'd8));
      vecs.push_back(mk("jbusy2",     5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,2'b00,4'b1111,1'b0,1'b0,1'b1,2'b00,16'd9));
      vecs.push_back(mk("jwait_end",  5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b00,4'b1111,1'b0,1'b0,1'b1,2'b00,16'd10));
      vecs.push_back(mk("jrun",       5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,2'b00,16'd10));
      vecs.push_back(mk("mw_enter",   5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,2'b00,4'b1111,1'b0,1'b0,1'b0,2'b00,16'd11));
      vecs.push_back(mk("mw_dbg_ign", 5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b01,4'b1111,1'b0,1'b0,1'b0,2'b00,16'd12));
      vecs.push_back(mk("mw_exit",    5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,2'b00,16'd12));
      vecs.push_back(mk("dbg11",      5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b11,4'b0000,1'b0,1'b0,1'b0,2'b00,16'd12));
      vecs.push_back(mk("halt_busy",  5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,2'b10,4'b1100,1'b1,1'b0,1'b0,2'b10,16'd13));
      vecs.push_back(mk("drain_busy", 5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,2'b00,4'b1111,1'b0,1'b0,1'b0,2'b10,16'd14));
      vecs.push_back(mk("drain1",     5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b00,4'b1100,1'b1,1'b0,1'b0,2'b10,16'd15));
      vecs.push_back(mk("drain2",     5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b00,4'b1100,1'b1,1'b0,1'b0,2'b10,16'd16));
      vecs.push_back(mk("halted",     5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,2'b00,4'b1111,1'b0,1'b1,1'b0,2'b10,16'd17));
      vecs.push_back(mk("halt_hold",  5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b1,1'b0,2'b01,4'b1111,1'b0,1'b1,1'b0,2'b10,16'd18));

      for (int i = 0; i < vecs.size(); i++) begin
         rs1 = vecs[i].rs1; u1 = vecs[i].u1; rs2 = vecs[i].rs2; u2 = vecs[i].u2;
         exrd = vecs[i].exrd; exwe = vecs[i].exwe; memrd = vecs[i].memrd; memwe = vecs[i].memwe;
         jmp = vecs[i].jmp; busy = vecs[i].busy; dbg = vecs[i].dbg;
         sb.push_back(vecs[i]);
         @(negedge clk);
         e = sb.pop_front();
         chk({e.name, "_stalls"}, {28'd0, sf, sd, se, sm}, {28'd0, e.stl});
         chk({e.name, "_bubble"}, {31'd0, bub}, {31'd0, e.bub});
         chk({e.name, "_halted"}, {31'd0, hlt}, {31'd0, e.hlt});
         @(posedge clk);
         #1;
         chk({e.name, "_flush"}, {31'd0, fl}, {31'd0, e.fl_after});
         chk({e.name, "_cause"}, {30'd0, cause}, {30'd0, e.cause_after});
         chk({e.name, "_cnt"}, {16'd0, cnt}, {16'd0, e.cnt_after});
      end

      // Reset while halted: everything clears without a clock edge.
      do_reset("rst_halted");

      // Breakpoint at cycle 10; dut drains 2 cycles, dut2 drains 1 cycle.
      for (int c = 0; c < 15; c++) begin
         dbg = (c == 10) ? 2'b01 : 2'b00;
         @(negedge clk);
         chk($sformatf("bkpt_c%0d_bubble", c), {31'd0, bub}, {31'd0, (c >= 10 && c <= 12)});
         chk($sformatf("bkpt_c%0d_halted", c), {31'd0, hlt}, {31'd0, (c >= 13)});
         chk($sformatf("bkpt1_c%0d_bubble", c), {31'd0, bub2}, {31'd0, (c >= 10 && c <= 11)});
         chk($sformatf("bkpt1_c%0d_halted", c), {31'd0, hlt2}, {31'd0, (c >= 12)});
         @(posedge clk);
         #1;
      end
      chk("bkpt_cause", {30'd0, cause}, 32'd1);
      chk("bkpt1_cause", {30'd0, cause2}, 32'd1);
      do_reset("rst_bkpt");

      // Pending flush survives a halt request, then reset mid-DRAIN clears it.
      jmp = 1'b1;
      @(posedge clk);
      #1;
      jmp = 1'b0;
      dbg = 2'b01;
      @(negedge clk);
      chk("rdrain_flush_n", {31'd0, fl}, 32'd1);
      chk("rdrain_bubble_n", {31'd0, bub}, 32'd1);
      @(posedge clk);
      #1;
      dbg = 2'b00;
      @(negedge clk);
      chk("rdrain_flush_held", {31'd0, fl}, 32'd1);
      chk("rdrain_in_drain", {31'd0, bub}, 32'd1);
      chk("rdrain_not_halted", {31'd0, hlt}, 32'd0);
      @(posedge clk);
      #1;
      do_reset("rst_drain");

      // Continuous hazard: 16-bit counter counts, 3-bit counter saturates at 7.
      rs1 = 5'd5; u1 = 1'b1; exrd = 5'd5; exwe = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
      end
      idle_inputs();
      chk("sat_cnt16", {16'd0, cnt}, 32'd10);
      chk("sat_cnt3", {29'd0, cnt2}, 32'd7);
      @(posedge clk);
      #1;
      chk("sat_cnt3_hold", {29'd0, cnt2}, 32'd7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
